// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C temperature-sensor responder.
// - i2c_state_e : responder FSM states
// - REG_*       : register map addresses
// - reg_read()  : register read mux shared by first-byte load and burst reload
package i2c_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StPtr,
        StPtrAck,
        StWdata,
        StWAck,
        StTx,
        StRxAck,
        StIgnore
    } i2c_state_e;

    localparam logic [7:0] REG_TEMP_MSB = 8'h00;
    localparam logic [7:0] REG_TEMP_LSB = 8'h01;
    localparam logic [7:0] REG_STATUS   = 8'h02;
    localparam logic [7:0] REG_CONFIG   = 8'h03;
    localparam logic [7:0] REG_ID       = 8'h0B;

    localparam logic [7:0] STATUS_VALUE = 8'h00;

    function automatic logic [7:0] reg_read(
        input logic [7:0]  addr,
        input logic [15:0] shadow,
        input logic [7:0]  cfg,
        input logic [7:0]  id
    );
        logic [7:0] data;
        case (addr)
            REG_TEMP_MSB: data = shadow[15:8];
            REG_TEMP_LSB: data = shadow[7:0];
            REG_STATUS:   data = STATUS_VALUE;
            REG_CONFIG:   data = cfg;
            REG_ID:       data = id;
            default:      data = 8'h00;
        endcase
        return data;
    endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Conditions the asynchronous SCL/SDA pad inputs: 2-FF synchroniser, a glitch filter that
// accepts a new level only after FILTER_LEN equal samples, and one-cycle event pulses.
// Ports:
//   i_clk, i_rst       system clock, synchronous active-high reset
//   i_scl, i_sda       raw pad levels (asynchronous)
//   o_sda              filtered SDA level
//   o_scl_rise/fall    one-cycle pulses on filtered SCL edges
//   o_start, o_stop    one-cycle pulses: SDA falls / rises while filtered SCL stays high
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [1:0]            r_scl_sync;
    logic [1:0]            r_sda_sync;
    logic [FILTER_LEN-1:0] r_scl_hist;
    logic [FILTER_LEN-1:0] r_sda_hist;
    logic                  r_scl;
    logic                  r_sda;
    logic                  r_scl_prev;
    logic                  r_sda_prev;

    // Reset to the idle bus level so leaving reset never fabricates a START.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= '1;
            r_sda_hist <= '1;
            r_scl      <= 1'b1;
            r_sda      <= 1'b1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_hist <= {r_scl_hist[FILTER_LEN-2:0], r_scl_sync[1]};
            r_sda_hist <= {r_sda_hist[FILTER_LEN-2:0], r_sda_sync[1]};
            if (&r_scl_hist) begin
                r_scl <= 1'b1;
            end else if (~|r_scl_hist) begin
                r_scl <= 1'b0;
            end
            if (&r_sda_hist) begin
                r_sda <= 1'b1;
            end else if (~|r_sda_hist) begin
                r_sda <= 1'b0;
            end
            r_scl_prev <= r_scl;
            r_sda_prev <= r_sda;
        end
    end

    assign o_sda      = r_sda;
    assign o_scl_rise = r_scl & ~r_scl_prev;
    assign o_scl_fall = ~r_scl & r_scl_prev;
    // SCL must be high on both samples so an SDA change around an SCL edge is not an event.
    assign o_start    = r_scl & r_scl_prev & r_sda_prev & ~r_sda;
    assign o_stop     = r_scl & r_scl_prev & ~r_sda_prev & r_sda;

endmodule

// File: rtl/i2c_tmp_responder.sv
// I2C target emulating the temperature sensor: pointer/config write, burst read of a
// snapshotted temperature word, ID register. Open-drain SDA only, never touches SCL.
// Ports:
//   i_clk, i_rst    system clock, synchronous active-high reset
//   i_scl, i_sda    pad levels (asynchronous)
//   o_sda_oe        1 = pull SDA low
//   i_temp_word     live temperature {MSB,LSB}, captured at each address match
//   o_cfg_reg       CONFIG register (0x03)
//   o_busy          high while a transfer is in progress
//   o_xfer_done     one-cycle pulse on the STOP that ends an addressed transfer
module i2c_tmp_responder
    import i2c_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR = 7'h48,
    parameter int unsigned FILTER_LEN = 4,
    parameter logic [7:0]  ID_VALUE   = 8'hCB
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_scl,
    input  logic        i_sda,
    output logic        o_sda_oe,
    input  logic [15:0] i_temp_word,
    output logic [7:0]  o_cfg_reg,
    output logic        o_busy,
    output logic        o_xfer_done
);

    logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    i2c_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_line_filter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_scl      (i_scl),
        .i_sda      (i_sda),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    i2c_state_e  r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [6:0]  r_shift, w_shift_nxt;
    logic [7:0]  r_ptr, w_ptr_nxt;
    logic [7:0]  r_cfg, w_cfg_nxt;
    logic [7:0]  r_tx, w_tx_nxt;
    logic [15:0] r_shadow, w_shadow_nxt;
    logic        r_sda_oe, w_sda_oe_nxt;
    logic        r_matched, w_matched_nxt;
    logic        r_rw, w_rw_nxt;
    logic        r_xfer_done, w_xfer_done_nxt;
    logic [7:0]  w_byte;
    logic        w_last_bit;

    assign w_byte     = {r_shift, w_sda};
    assign w_last_bit = (r_cnt == 4'd7);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_ptr_nxt       = r_ptr;
        w_cfg_nxt       = r_cfg;
        w_tx_nxt        = r_tx;
        w_shadow_nxt    = r_shadow;
        w_sda_oe_nxt    = r_sda_oe;
        w_matched_nxt   = r_matched;
        w_rw_nxt        = r_rw;
        w_xfer_done_nxt = 1'b0;

        // START outranks STOP, which outranks any SCL edge in the same cycle.
        if (w_start) begin
            w_state_nxt  = StAddr;
            w_cnt_nxt    = 4'd0;
            w_sda_oe_nxt = 1'b0;
        end else if (w_stop) begin
            w_state_nxt     = StIdle;
            w_sda_oe_nxt    = 1'b0;
            w_xfer_done_nxt = r_matched;
            w_matched_nxt   = 1'b0;
        end else if (w_scl_rise) begin
            case (r_state)
                StAddr, StPtr, StWdata: begin
                    w_shift_nxt = w_byte[6:0];
                    w_cnt_nxt   = r_cnt + 4'd1;
                    if (w_last_bit) begin
                        w_cnt_nxt = 4'd0;
                        case (r_state)
                            StAddr: begin
                                if (w_byte[7:1] == SLAVE_ADDR) begin
                                    w_state_nxt   = StAddrAck;
                                    w_matched_nxt = 1'b1;
                                    w_rw_nxt      = w_byte[0];
                                    w_shadow_nxt  = i_temp_word;
                                end else begin
                                    w_state_nxt = StIgnore;
                                end
                            end
                            StPtr: begin
                                w_ptr_nxt   = w_byte;
                                w_state_nxt = StPtrAck;
                            end
                            default: begin
                                if (r_ptr == REG_CONFIG) begin
                                    w_cfg_nxt = w_byte;
                                end
                                w_ptr_nxt   = r_ptr + 8'd1;
                                w_state_nxt = StWAck;
                            end
                        endcase
                    end
                end
                StAddrAck: begin
                    if (r_rw) begin
                        w_tx_nxt    = reg_read(r_ptr, r_shadow, r_cfg, ID_VALUE);
                        w_state_nxt = StTx;
                    end else begin
                        w_state_nxt = StPtr;
                    end
                end
                StPtrAck, StWAck: w_state_nxt = StWdata;
                StTx: begin
                    w_tx_nxt  = {r_tx[6:0], 1'b0};
                    w_cnt_nxt = r_cnt + 4'd1;
                    if (w_last_bit) begin
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = StRxAck;
                    end
                end
                StRxAck: begin
                    if (!w_sda) begin
                        w_ptr_nxt   = r_ptr + 8'd1;
                        w_tx_nxt    = reg_read(r_ptr + 8'd1, r_shadow, r_cfg, ID_VALUE);
                        w_state_nxt = StTx;
                    end else begin
                        w_state_nxt = StIgnore;
                    end
                end
                default: ;
            endcase
        end else if (w_scl_fall) begin
            // Drive for the bit that starts now, decided by the state the last rise left us in.
            case (r_state)
                StAddrAck, StPtrAck, StWAck: w_sda_oe_nxt = 1'b1;
                StTx:                        w_sda_oe_nxt = ~r_tx[7];
                default:                     w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= 4'd0;
            r_shift     <= 7'd0;
            r_ptr       <= 8'h00;
            r_cfg       <= 8'h00;
            r_tx        <= 8'h00;
            r_shadow    <= 16'h0000;
            r_sda_oe    <= 1'b0;
            r_matched   <= 1'b0;
            r_rw        <= 1'b0;
            r_xfer_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cfg       <= w_cfg_nxt;
            r_tx        <= w_tx_nxt;
            r_shadow    <= w_shadow_nxt;
            r_sda_oe    <= w_sda_oe_nxt;
            r_matched   <= w_matched_nxt;
            r_rw        <= w_rw_nxt;
            r_xfer_done <= w_xfer_done_nxt;
        end
    end

    assign o_sda_oe    = r_sda_oe;
    assign o_cfg_reg   = r_cfg;
    assign o_busy      = (r_state != StIdle);
    assign o_xfer_done = r_xfer_done;

endmodule

// File: tb/tb_i2c_tmp_responder.sv
// Directed bench: bit-banged I2C master on a pulled-up open-drain SDA wire.
module tb_i2c_tmp_responder;

    localparam int QTR = 20;  // clock cycles per quarter SCL period

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic [15:0] temp_word = 16'h0C80;
    logic        sda_oe, busy, xfer_done;
    logic [7:0]  cfg_reg;
    logic        bus_scl, bus_sda;

    assign bus_scl = m_scl;
    assign bus_sda = m_sda & ~sda_oe;

    int n_compared   = 0;
    int n_mismatched = 0;
    int n_done       = 0;
    int n_oe_high    = 0;
    int n_stable_bad = 0;
    int n_idle_drive = 0;
    logic prev_oe  = 1'b0;
    logic prev_scl = 1'b1;

    always #5 clk = ~clk;

    i2c_tmp_responder dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl       (bus_scl),
        .i_sda       (bus_sda),
        .o_sda_oe    (sda_oe),
        .i_temp_word (temp_word),
        .o_cfg_reg   (cfg_reg),
        .o_busy      (busy),
        .o_xfer_done (xfer_done)
    );

    // Bus monitors: pulse counting, SDA stability while SCL high, release when idle.
    always @(negedge clk) begin
        if (xfer_done) n_done++;
        if (sda_oe) n_oe_high++;
        if (prev_scl && bus_scl && (sda_oe != prev_oe)) n_stable_bad++;
        if (!busy && sda_oe) n_idle_drive++;
        prev_oe  = sda_oe;
        prev_scl = bus_scl;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic q();
        repeat (QTR) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        m_sda = 1'b0; q();
        m_scl = 1'b0; q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; q();
        m_scl = 1'b1; q();
        m_sda = 1'b1; q();
        q();
    endtask

    task automatic put_bit(input logic b, input logic glitch);
        m_sda = b;
        if (glitch) begin
            repeat (5) @(negedge clk);
            m_scl = 1'b1;
            repeat (2) @(negedge clk);
            m_scl = 1'b0;
        end
        q();
        m_scl = 1'b1; q(); q();
        m_scl = 1'b0; q();
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; q();
        m_scl = 1'b1; q();
        b = bus_sda; q();
        m_scl = 1'b0; q();
    endtask

    task automatic write_byte(input logic [7:0] d, input int glitch_at, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_at);
        get_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            d[i] = b;
        end
        put_bit(~ack, 1'b0);
    endtask

    task automatic wr_ptr(input string tag, input logic [7:0] p);
        logic ack;
        i2c_start();
        write_byte(8'h90, -1, ack);
        check_eq({tag, "_addr_w_ack"}, 16'(ack), 16'd1);
        write_byte(p, -1, ack);
        check_eq({tag, "_ptr_ack"}, 16'(ack), 16'd1);
    endtask

    task automatic rd_begin(input string tag);
        logic ack;
        i2c_start();
        write_byte(8'h91, -1, ack);
        check_eq({tag, "_addr_r_ack"}, 16'(ack), 16'd1);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        int         done0;
        int         oe0;

        repeat (5) @(negedge clk);
        check_eq("rst_sda_oe", 16'(sda_oe), 16'd0);
        check_eq("rst_cfg", 16'(cfg_reg), 16'h00);
        check_eq("rst_busy", 16'(busy), 16'd0);
        check_eq("rst_xfer_done", 16'(xfer_done), 16'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 1) pointer write, repeated START, 2-byte read
        done0 = n_done;
        wr_ptr("t1", 8'h00);
        rd_begin("t1");
        read_byte(1'b1, d); check_eq("t1_byte0", 16'(d), 16'h0C);
        read_byte(1'b0, d); check_eq("t1_byte1", 16'(d), 16'h80);
        check_eq("t1_busy_mid", 16'(busy), 16'd1);
        i2c_stop(); q();
        check_eq("t1_busy_end", 16'(busy), 16'd0);
        check_eq("t1_done_pulses", 16'(n_done - done0), 16'd1);

        // 2) foreign address 0x49
        done0 = n_done;
        oe0   = n_oe_high;
        i2c_start();
        write_byte(8'h92, -1, ack); check_eq("t2_addr_nack", 16'(ack), 16'd0);
        write_byte(8'h00, -1, ack); check_eq("t2_data_nack", 16'(ack), 16'd0);
        i2c_stop(); q();
        check_eq("t2_oe_cycles", 16'(n_oe_high - oe0), 16'd0);
        check_eq("t2_done_pulses", 16'(n_done - done0), 16'd0);

        // 3) CONFIG write/readback, ID read
        wr_ptr("t3w", 8'h03);
        write_byte(8'hA5, -1, ack); check_eq("t3_data_ack", 16'(ack), 16'd1);
        i2c_stop(); q();
        check_eq("t3_cfg_reg", 16'(cfg_reg), 16'hA5);
        wr_ptr("t3r", 8'h03);
        rd_begin("t3r");
        read_byte(1'b0, d); check_eq("t3_cfg_read", 16'(d), 16'hA5);
        i2c_stop();
        wr_ptr("t3id", 8'h0B);
        rd_begin("t3id");
        read_byte(1'b0, d); check_eq("t3_id_read", 16'(d), 16'hCB);
        i2c_stop();

        // 4) temperature changes mid-burst: snapshot stays coherent
        wr_ptr("t4", 8'h00);
        rd_begin("t4");
        read_byte(1'b1, d); check_eq("t4_byte0", 16'(d), 16'h0C);
        temp_word = 16'h0D00;
        read_byte(1'b0, d); check_eq("t4_byte1_snap", 16'(d), 16'h80);
        i2c_stop();
        wr_ptr("t4b", 8'h00);
        rd_begin("t4b");
        read_byte(1'b0, d); check_eq("t4_new_msb", 16'(d), 16'h0D);
        i2c_stop();

        // 5) pointer wrap 0xFF -> 0x00
        temp_word = 16'h0C80;
        wr_ptr("t5", 8'hFF);
        rd_begin("t5");
        read_byte(1'b1, d); check_eq("t5_reg_ff", 16'(d), 16'h00);
        read_byte(1'b0, d); check_eq("t5_wrap_reg0", 16'(d), 16'h0C);
        i2c_stop();

        // 6) SCL glitch during address byte, then reset while transmitting
        done0 = n_done;
        i2c_start();
        write_byte(8'h90, 4, ack); check_eq("t6_glitch_addr_ack", 16'(ack), 16'd1);
        write_byte(8'h00, -1, ack); check_eq("t6_ptr_ack", 16'(ack), 16'd1);
        rd_begin("t6");
        check_eq("t6_tx_drive", 16'(sda_oe), 16'd1);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check_eq("t6_rst_release", 16'(sda_oe), 16'd0);
        @(negedge clk); rst = 1'b0;
        read_byte(1'b0, d); check_eq("t6_ignored_read", 16'(d), 16'hFF);
        i2c_stop(); q();
        check_eq("t6_cfg_after_rst", 16'(cfg_reg), 16'h00);
        check_eq("t6_no_done_after_rst", 16'(n_done - done0), 16'd0);
        wr_ptr("t6b", 8'h00);
        rd_begin("t6b");
        read_byte(1'b1, d); check_eq("t6_recover_b0", 16'(d), 16'h0C);
        read_byte(1'b0, d); check_eq("t6_recover_b1", 16'(d), 16'h80);
        i2c_stop(); q();
        check_eq("t6_done_pulses", 16'(n_done - done0), 16'd1);

        check_eq("sda_stable_scl_high", 16'(n_stable_bad), 16'd0);
        check_eq("idle_sda_released", 16'(n_idle_drive), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
